// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SPI serial clock generator with frame, burst and strobe sequencing
module spi_sclk_gen #(
  parameter  int DIV_W    = 16,
  parameter  int MAX_BITS = 32,
  parameter  int GAP_W    = 8,
  localparam int BITS_W   = $clog2(MAX_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              stop,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  div,
  input  logic [BITS_W-1:0] nbits,
  input  logic              burst,
  input  logic [GAP_W-1:0]  gap,
  output logic              sclk,
  output logic              sclk_oe,
  output logic              busy,
  output logic              shift_stb,
  output logic              sample_stb,
  output logic              frame_done,
  output logic [BITS_W-1:0] bit_idx
);

  localparam int EDGE_W = BITS_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_e;

  state_e            state_q, state_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              burst_q, burst_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BITS_W-1:0] nbits_q, nbits_d;
  logic [BITS_W-1:0] bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic              sclk_q, sclk_d;
  logic              sclk_oe_q, sclk_oe_d;
  logic              shift_q, shift_d;
  logic              sample_q, sample_d;
  logic              done_q, done_d;

  logic [BITS_W-1:0] nbits_clamp;
  logic [EDGE_W-1:0] last_edge;
  logic [EDGE_W-1:0] edge_next;
  logic              lead;

  // Clamp the requested frame length into 1..MAX_BITS before it is latched
  always_comb begin
    nbits_clamp = nbits;
    if (nbits == '0) begin
      nbits_clamp = BITS_W'(1);
    end else if (nbits > BITS_W'(MAX_BITS)) begin
      nbits_clamp = BITS_W'(MAX_BITS);
    end
  end

  assign last_edge = {nbits_q, 1'b0};
  assign edge_next = edge_cnt_q + EDGE_W'(1);
  assign lead      = edge_next[0];

  // Next state, counters and registered strobes
  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    burst_d    = burst_q;
    div_d      = div_q;
    nbits_d    = nbits_q;
    gap_d      = gap_q;
    div_cnt_d  = div_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    edge_cnt_d = edge_cnt_q;
    bit_idx_d  = sample_q ? bit_idx_q + BITS_W'(1) : bit_idx_q;
    sclk_d     = sclk_q;
    sclk_oe_d  = en;
    shift_d    = 1'b0;
    sample_d   = 1'b0;
    done_d     = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      sclk_d  = cpol;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          sclk_d = cpol;
          if (start && !stop) begin
            state_d    = S_RUN;
            cpol_d     = cpol;
            cpha_d     = cpha;
            burst_d    = burst;
            div_d      = div;
            nbits_d    = nbits_clamp;
            gap_d      = gap;
            div_cnt_d  = '0;
            edge_cnt_d = '0;
            bit_idx_d  = '0;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_IDLE;
            sclk_d  = cpol_q;
          end else if (edge_cnt_q == last_edge) begin
            done_d     = 1'b1;
            div_cnt_d  = '0;
            edge_cnt_d = '0;
            gap_cnt_d  = '0;
            if (!burst_q) begin
              state_d = S_IDLE;
            end else if (gap_q == '0) begin
              bit_idx_d = '0;
            end else begin
              state_d = S_GAP;
            end
          end else if (div_cnt_q == div_q) begin
            div_cnt_d  = '0;
            sclk_d     = ~sclk_q;
            edge_cnt_d = edge_next;
            if (!cpha_q) begin
              sample_d = lead;
              shift_d  = !lead && (edge_next != last_edge);
            end else begin
              shift_d  = lead;
              sample_d = !lead;
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (stop) begin
            state_d = S_IDLE;
            sclk_d  = cpol_q;
          end else if (gap_cnt_q == gap_q - GAP_W'(1)) begin
            state_d   = S_RUN;
            bit_idx_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Latched frame configuration, counters and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      burst_q    <= 1'b0;
      div_q      <= '0;
      nbits_q    <= '0;
      gap_q      <= '0;
      div_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      edge_cnt_q <= '0;
      bit_idx_q  <= '0;
      sclk_q     <= 1'b0;
      sclk_oe_q  <= 1'b0;
      shift_q    <= 1'b0;
      sample_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      burst_q    <= burst_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      gap_q      <= gap_d;
      div_cnt_q  <= div_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      bit_idx_q  <= bit_idx_d;
      sclk_q     <= sclk_d;
      sclk_oe_q  <= sclk_oe_d;
      shift_q    <= shift_d;
      sample_q   <= sample_d;
      done_q     <= done_d;
    end
  end

  assign sclk       = sclk_q;
  assign sclk_oe    = sclk_oe_q;
  assign busy       = (state_q != S_IDLE);
  assign shift_stb  = shift_q;
  assign sample_stb = sample_q;
  assign frame_done = done_q;
  assign bit_idx    = bit_idx_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb/tb_spi_sclk_gen.sv - scoreboard bench for spi_sclk_gen
module tb_spi_sclk_gen;

  localparam int DIV_W    = 16;
  localparam int MAX_BITS = 32;
  localparam int GAP_W    = 8;
  localparam int BITS_W   = $clog2(MAX_BITS + 1);

  localparam int EV_EDGE   = 1;
  localparam int EV_SAMPLE = 2;
  localparam int EV_SHIFT  = 3;
  localparam int EV_DONE   = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst, en, start, stop, cpol, cpha, burst;
  logic [DIV_W-1:0]  div;
  logic [BITS_W-1:0] nbits;
  logic [GAP_W-1:0]  gap;
  logic              sclk, sclk_oe, busy, shift_stb, sample_stb, frame_done;
  logic [BITS_W-1:0] bit_idx;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  ev_t  sb[$];
  logic sclk_prev = 1'b0;

  spi_sclk_gen #(.DIV_W(DIV_W), .MAX_BITS(MAX_BITS), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
    .cpol(cpol), .cpha(cpha), .div(div), .nbits(nbits), .burst(burst), .gap(gap),
    .sclk(sclk), .sclk_oe(sclk_oe), .busy(busy), .shift_stb(shift_stb),
    .sample_stb(sample_stb), .frame_done(frame_done), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected edges/strobes of one frame starting at absolute cycle s
  task automatic push_frame(input int s, input int d, input int n, input bit cp, input bit ph);
    int b;
    int c;
    bit ld;
    b = 0;
    for (int k = 1; k <= 2 * n; k++) begin
      c  = s + (d + 1) * k;
      ld = (k % 2) == 1;
      sb.push_back('{c, EV_EDGE, int'(cp ^ ld)});
      if ((!ph && ld) || (ph && !ld)) begin
        sb.push_back('{c, EV_SAMPLE, b});
        b++;
      end else if (!(!ph && !ld && k == 2 * n)) begin
        sb.push_back('{c, EV_SHIFT, b});
      end
    end
    sb.push_back('{s + (d + 1) * 2 * n + 1, EV_DONE, n});
  endtask

  task automatic trunc(input int c);
    while (sb.size() > 0 && sb[$].cyc >= c) void'(sb.pop_back());
  endtask

  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    chk("sb_avail", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ev_cyc", cyc, e.cyc);
      chk("ev_kind", kind, e.kind);
      chk("ev_val", val, e.val);
    end
  endtask

  // Monitor: every observed edge/strobe is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && sclk !== sclk_prev) expect_ev(EV_EDGE, int'(sclk));
      if (sample_stb) expect_ev(EV_SAMPLE, int'(bit_idx));
      if (shift_stb)  expect_ev(EV_SHIFT, int'(bit_idx));
      if (frame_done) expect_ev(EV_DONE, int'(bit_idx));
    end
    sclk_prev = sclk;
  end

  task automatic start_frame(input int d, input int n_in, input bit cp, input bit ph,
                             input bit b, input int g, input int n_model, output int s);
    div = DIV_W'(d); nbits = BITS_W'(n_in); cpol = cp; cpha = ph; burst = b; gap = GAP_W'(g);
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    push_frame(s, d, n_model, cp, ph);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int s, input int exp_rel, input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_lat"}, cyc - s, exp_rel);
    #1;
    chk({tag, "_sb_left"}, sb.size(), 0);
    chk({tag, "_sclk_idle"}, sclk, cpol);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int s;
    rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; cpol = 1'b1; cpha = 1'b0;
    burst = 1'b0; div = '0; nbits = '0; gap = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_oe", sclk_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_shift", shift_stb, 0);
    chk("rst_sample", sample_stb, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_bidx", bit_idx, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_sclk", sclk, 1);
    chk("post_rst_oe", sclk_oe, 1);
    cpol = 1'b0;
    @(negedge clk);

    // Mode 0, div=1, 8 bits
    start_frame(1, 8, 0, 0, 0, 0, 8, s);
    wait_idle(s, 33, "mode0");

    // Mode 3, div=0, 4 bits
    start_frame(0, 4, 1, 1, 0, 0, 4, s);
    wait_idle(s, 9, "mode3");

    // Burst, gap=3, stopped in the second gap
    start_frame(0, 2, 0, 0, 1, 3, 2, s);
    push_frame(s + 8, 0, 2, 0, 0);
    push_frame(s + 16, 0, 2, 0, 0);
    while (cyc - s < 14) begin
      @(negedge clk);
      if (cyc - s >= 5 && cyc - s <= 7) begin
        chk("gap_sclk", sclk, 0);
        chk("gap_busy", busy, 1);
      end
      if (cyc - s == 13) begin
        stop = 1'b1;
        trunc(s + 14);
      end
    end
    stop = 1'b0;
    burst = 1'b0;
    chk("burst_stop_busy", busy, 0);
    chk("burst_stop_sclk", sclk, 0);
    repeat (6) @(negedge clk);
    chk("burst_stay_idle", busy, 0);
    chk("burst_sb_left", sb.size(), 0);

    // Abort after the 5th edge, then a fresh full frame
    start_frame(0, 8, 0, 0, 0, 0, 8, s);
    while (cyc - s < 5) @(negedge clk);
    stop = 1'b1;
    trunc(s + 6);
    @(negedge clk);
    stop = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sclk", sclk, 0);
    chk("abort_done", frame_done, 0);
    repeat (3) @(negedge clk);
    chk("abort_sb_left", sb.size(), 0);
    start_frame(2, 8, 0, 0, 0, 0, 8, s);
    wait_idle(s, 49, "restart");

    // nbits=0 clamps to one bit, nbits=MAX_BITS+5 clamps to MAX_BITS
    start_frame(0, 0, 0, 0, 0, 0, 1, s);
    wait_idle(s, 3, "nbits0");
    start_frame(0, MAX_BITS + 5, 0, 1, 0, 0, MAX_BITS, s);
    wait_idle(s, 2 * MAX_BITS + 1, "nbits_max");

    // Config changes and start during a frame are ignored
    start_frame(1, 3, 0, 0, 0, 0, 3, s);
    while (cyc - s < 3) @(negedge clk);
    div = DIV_W'(5); nbits = BITS_W'(10); cpha = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_idle(s, 13, "cfg_hold");

    // Enable dropped mid-frame
    start_frame(1, 8, 0, 0, 0, 0, 8, s);
    while (cyc - s < 7) @(negedge clk);
    en = 1'b0;
    trunc(s + 8);
    @(negedge clk);
    chk("en_oe", sclk_oe, 0);
    chk("en_busy", busy, 0);
    chk("en_shift", shift_stb, 0);
    chk("en_sample", sample_stb, 0);
    en = 1'b1;
    @(negedge clk);
    chk("en_oe_back", sclk_oe, 1);
    chk("en_sb_left", sb.size(), 0);

    // Asynchronous reset mid-frame
    start_frame(1, 8, 0, 0, 0, 0, 8, s);
    while (cyc - s < 9) @(negedge clk);
    sb.delete();
    #2 rst = 1'b1;
    #1;
    chk("arst_sclk", sclk, 0);
    chk("arst_oe", sclk_oe, 0);
    chk("arst_busy", busy, 0);
    chk("arst_bidx", bit_idx, 0);
    chk("arst_strobes", {shift_stb, sample_stb, frame_done}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_idle", busy, 0);
    chk("arst_oe_back", sclk_oe, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
